vx_commit_arbiter: RTL and testbench
====================================

# vx_commit_arbiter

Producer side of the writeback interface for one issue slot. Merges the per-execution-unit commit streams into the single writeback stream that releases scoreboard register reservations. Multi-beat results are kept contiguous and end with `eop`. Commits that do not write a register are drained without being forwarded. The top level instantiates one block per issue slot.

## Interface
- `NUM_INPUTS`, default 4: number of execution-unit commit streams (≥1).
- `WIS_W`, default 2: warp-in-slot index width.
- `NR_W`, default 6: register index width.
- `NUM_THREADS`, default 4: lanes per beat.
- `XLEN`, default 32: data width per lane.
- `UUID_W`, default 1: instruction tag width.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `commit_valid`, in, `NUM_INPUTS`: per-unit beat valid.
- `commit_ready`, out, `NUM_INPUTS`: per-unit beat accepted.
- `commit_data`, in, `NUM_INPUTS` × `commit_t`: fields {uuid, wis, tmask, PC, wb, rd, data[NUM_THREADS][XLEN], sop, eop}.
- `wb_valid`, out, 1: writeback beat valid. No backpressure.
- `wb_data`, out, `wb_t`: fields {uuid, wis, tmask, PC, rd, data, sop, eop}.
- `perf_commits`, out, 32: count of forwarded `eop` beats.

## Operation
- Each cycle at most one input is granted. A beat transfers when `commit_valid[g] && commit_ready[g]`. `commit_ready` is one-hot or zero.
- Arbitration is round-robin. Priority starts at the unit after the last unit whose `eop` beat transferred. Pointer starts at 0 after reset.
- Lock:
  - When a beat with `eop=0` transfers, the grant locks to that unit.
  - While locked, `commit_ready` is asserted only for the locked unit. If that unit is not valid, no beat transfers; other units wait.
  - The lock clears on the locked unit's `eop` beat transfer.
- A beat with `sop=1&&eop=1` never locks. The pointer advances past the winner on every `eop` transfer.
- Beats with `wb=0` are accepted normally, with the same lock and pointer rules, but are not forwarded. `wb_valid` stays 0 for them.
- Beats with `wb=1` are registered into `wb_data` with `wb_valid=1` for exactly one cycle. A new beat may follow every cycle.
- `perf_commits` increments by 1 on each cycle where `wb_valid && wb_data.eop`. It wraps modulo 2^32.
- Illegal input: `sop=1` while locked on another packet of the same unit, or `eop` arriving on an unlocked unit with `sop=0`. Both fire a simulation assertion. Hardware still honours `eop` to clear the lock.

## Timing
- Latency: input transfer at cycle N gives `wb_valid` at N+1. Throughput is 1 beat/cycle.
- `commit_ready` is combinational from `commit_valid`, lock state and pointer.
- Reset (async assert, sync-safe deassert):
  - `wb_valid=0`, `wb_data=0`, `perf_commits=0`, pointer=0, lock cleared.
  - All `commit_ready` are 0 during reset.
- Reset asserted mid-packet drops the remainder of that packet; no `eop` is emitted. The scoreboard is reset on the same signal.
- Simultaneous valid on all inputs: strict rotation, each unit granted once per `NUM_INPUTS` packets.
- Single valid input with the pointer elsewhere: still granted the same cycle. No idle bubble.

## Structure
- Shared package holds:
  - `commit_t` and `wb_t` packed structs.
  - Reset value of `wb_t`.
  - `PERF_COMMIT_W = 32`.
- Sub-module `vx_rr_arbiter` (`NUM_REQS`, `LOCK_ENABLE`): request vector, lock/unlock strobes, one-hot grant, grant index.
- Top block holds the lock register, `wb=0` filter, output register and perf counter.

## Test plan
- Single unit, 3 back-to-back single-beat `wb=1` commits (rd=5,6,7) → `wb_valid` high on 3 consecutive cycles starting 1 cycle later, `rd` 5,6,7, each `eop=1`; `perf_commits=3`.
- All 4 units valid continuously, single-beat → grants 0,1,2,3,0,… one per cycle; `wb_data` fields match the granted unit.
- Unit 1 sends a 3-beat packet (sop/–/eop) with a 1-cycle gap before the last beat while unit 2 is valid → unit 2 gets no ready until unit 1's `eop` transfers; output beats contiguous from unit 1 except the gap cycle (`wb_valid=0`).
- Unit 0 commit with `wb=0` then `wb=1` rd=9 → first accepted with no output; second produces one `wb_valid` beat, rd=9; `perf_commits=1`.
- Reset asserted mid-packet on unit 3 → `wb_valid` and all `commit_ready` drop to 0 asynchronously; after release unit 0 wins first (pointer=0) and no lock persists.
- 2^32−1 preload via force, then one commit → `perf_commits` wraps to 0.

Source files
------------

// File: rtl/vx_commit_arbiter_pkg.sv
// Shared types for the commit arbiter: per-unit commit beat, writeback beat,
// and the widths both are built from.
package vx_commit_arbiter_pkg;

  localparam int WIS_W         = 2;
  localparam int NR_W          = 6;
  localparam int NUM_THREADS   = 4;
  localparam int XLEN          = 32;
  localparam int UUID_W        = 1;
  localparam int PC_W          = 32;
  localparam int PERF_COMMIT_W = 32;

  typedef struct packed {
    logic [UUID_W-1:0]                 uuid;
    logic [WIS_W-1:0]                  wis;
    logic [NUM_THREADS-1:0]            tmask;
    logic [PC_W-1:0]                   PC;
    logic                              wb;
    logic [NR_W-1:0]                   rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]  data;
    logic                              sop;
    logic                              eop;
  } commit_t;

  typedef struct packed {
    logic [UUID_W-1:0]                 uuid;
    logic [WIS_W-1:0]                  wis;
    logic [NUM_THREADS-1:0]            tmask;
    logic [PC_W-1:0]                   PC;
    logic [NR_W-1:0]                   rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]  data;
    logic                              sop;
    logic                              eop;
  } wb_t;

  localparam wb_t WB_RESET = '0;

endpackage

// File: rtl/vx_commit_arbiter_if.sv
// Commit-side handshake bundle (per-unit valid/ready/data) plus the
// writeback output; master is the arbiter, slave is the execution-unit side.
interface vx_commit_arbiter_if #(
  parameter int NUM_INPUTS = 4
);
  import vx_commit_arbiter_pkg::*;

  logic [NUM_INPUTS-1:0] commit_valid;
  logic [NUM_INPUTS-1:0] commit_ready;
  commit_t               commit_data [NUM_INPUTS];
  logic                  wb_valid;
  wb_t                   wb_data;

  modport master (
    input  commit_valid, commit_data,
    output commit_ready, wb_valid, wb_data
  );

  modport slave (
    output commit_valid, commit_data,
    input  commit_ready, wb_valid, wb_data
  );

endinterface

// File: rtl/vx_commit_arbiter_rr_arbiter.sv
// Round-robin arbiter with packet lock: combinational grant, pointer moves
// past the winner on each unlock strobe; a held lock pins the grant to one index.
module vx_rr_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int LOCK_ENABLE = 1,
  localparam int IDX_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                lock,
  input  logic [IDX_W-1:0]    lock_index,
  input  logic                unlock,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [IDX_W-1:0]    grant_index,
  output logic                grant_valid
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_next;
  logic             lock_on;

  assign lock_on = (LOCK_ENABLE != 0) && lock;

  always_comb begin : p_grant
    int               idx;
    logic [IDX_W-1:0] cand;
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    idx          = 0;
    cand         = '0;
    if (lock_on) begin
      grant_index = lock_index;
      grant_valid = requests[lock_index];
    end else begin
      // First requester at or after the pointer, wrapping modulo NUM_REQS.
      for (int k = 0; k < NUM_REQS; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQS) idx = idx - NUM_REQS;
        cand = IDX_W'(idx);
        if (!grant_valid && requests[cand]) begin
          grant_valid = 1'b1;
          grant_index = cand;
        end
      end
    end
    grant_onehot[grant_index] = grant_valid;
  end

  assign ptr_next = (grant_index == IDX_W'(NUM_REQS - 1)) ? '0 : grant_index + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (unlock) begin
      ptr_q <= ptr_next;
    end
  end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Merges per-unit commit streams into one writeback stream, one cycle of latency.
// Units see ready only when granted; writeback side has no backpressure.
module vx_commit_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int WIS_W       = vx_commit_arbiter_pkg::WIS_W,
  parameter int NR_W        = vx_commit_arbiter_pkg::NR_W,
  parameter int NUM_THREADS = vx_commit_arbiter_pkg::NUM_THREADS,
  parameter int XLEN        = vx_commit_arbiter_pkg::XLEN,
  parameter int UUID_W      = vx_commit_arbiter_pkg::UUID_W
) (
  input  logic                                          clk,
  input  logic                                          reset,
  vx_commit_arbiter_if.master                           bus,
  output logic [vx_commit_arbiter_pkg::PERF_COMMIT_W-1:0] perf_commits
);
  import vx_commit_arbiter_pkg::*;

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  // Field widths are fixed by the shared struct types; overriding them here is an error.
  if (WIS_W != vx_commit_arbiter_pkg::WIS_W || NR_W != vx_commit_arbiter_pkg::NR_W ||
      NUM_THREADS != vx_commit_arbiter_pkg::NUM_THREADS ||
      XLEN != vx_commit_arbiter_pkg::XLEN || UUID_W != vx_commit_arbiter_pkg::UUID_W)
  begin : g_width_check
    $error("vx_commit_arbiter: width parameters must match vx_commit_arbiter_pkg");
  end

  logic [NUM_INPUTS-1:0] grant_onehot;
  logic [IDX_W-1:0]      grant_index;
  logic                  grant_valid;
  logic                  locked_q;
  logic [IDX_W-1:0]      lock_idx_q;
  logic                  xfer;
  logic                  unlock;
  commit_t               beat;
  wb_t                   beat_wb;
  logic                  wb_valid_q;
  wb_t                   wb_data_q;
  logic [PERF_COMMIT_W-1:0] perf_q;

  vx_rr_arbiter #(
    .NUM_REQS    (NUM_INPUTS),
    .LOCK_ENABLE (1)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (bus.commit_valid),
    .lock         (locked_q),
    .lock_index   (lock_idx_q),
    .unlock       (unlock),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .grant_valid  (grant_valid)
  );

  // Grant already implies valid, so ready doubles as the transfer strobe.
  assign bus.commit_ready = grant_onehot & {NUM_INPUTS{reset}};
  assign xfer             = grant_valid & reset;
  assign beat             = bus.commit_data[grant_index];
  assign unlock           = xfer & beat.eop;

  always_comb begin
    beat_wb       = WB_RESET;
    beat_wb.uuid  = beat.uuid;
    beat_wb.wis   = beat.wis;
    beat_wb.tmask = beat.tmask;
    beat_wb.PC    = beat.PC;
    beat_wb.rd    = beat.rd;
    beat_wb.data  = beat.data;
    beat_wb.sop   = beat.sop;
    beat_wb.eop   = beat.eop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else if (xfer) begin
      if (beat.eop) begin
        locked_q <= 1'b0;
      end else begin
        locked_q   <= 1'b1;
        lock_idx_q <= grant_index;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= WB_RESET;
    end else begin
      wb_valid_q <= xfer & beat.wb;
      if (xfer && beat.wb) wb_data_q <= beat_wb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (wb_valid_q && wb_data_q.eop) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign perf_commits = perf_q;

  // Malformed packet framing; the lock is still released on eop regardless.
  a_sop_while_locked: assert property (@(posedge clk) disable iff (!reset)
    (xfer && locked_q) |-> !beat.sop);
  a_eop_without_sop: assert property (@(posedge clk) disable iff (!reset)
    (xfer && !locked_q && beat.eop) |-> beat.sop);

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Bench for vx_commit_arbiter: vector table, hand-written lock/reset/wrap
// sequences, and a randomized run against a queue-based reference model.
module tb_vx_commit_arbiter;
  import vx_commit_arbiter_pkg::*;

  localparam int N = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] perf_commits;
  int          n_cmp = 0;
  int          n_bad = 0;

  vx_commit_arbiter_if #(.NUM_INPUTS(N)) bus ();

  vx_commit_arbiter #(.NUM_INPUTS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .perf_commits (perf_commits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic        wb;
    logic [5:0]  rdb;
    logic [3:0]  exp_rdy;
    logic        exp_wbv;
    logic [5:0]  exp_rd;
    logic [1:0]  exp_wis;
    logic [31:0] exp_perf;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic commit_t mk(input int u, input logic sop, input logic eop,
                                 input logic wb, input logic [5:0] rd);
    commit_t c;
    c       = '0;
    c.uuid  = 1'(u);
    c.wis   = 2'(u);
    c.tmask = 4'hF;
    c.PC    = 32'h100 + 32'(rd);
    c.wb    = wb;
    c.rd    = rd;
    for (int l = 0; l < NUM_THREADS; l++) c.data[l] = {18'd0, rd, 8'(l)};
    c.sop   = sop;
    c.eop   = eop;
    return c;
  endfunction

  task automatic drv(input int u, input logic v, input commit_t c);
    bus.commit_valid[u] = v;
    bus.commit_data[u]  = c;
  endtask

  task automatic idle_all();
    for (int u = 0; u < N; u++) drv(u, 1'b0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic [3:0] er, input logic ev,
                        input logic [5:0] erd, input logic [1:0] ewis, input logic eeop);
    chk({tag, ".ready"}, 64'(bus.commit_ready), 64'(er));
    chk({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'(ev));
    if (ev) begin
      chk({tag, ".rd"}, 64'(bus.wb_data.rd), 64'(erd));
      chk({tag, ".wis"}, 64'(bus.wb_data.wis), 64'(ewis));
      chk({tag, ".eop"}, 64'(bus.wb_data.eop), 64'(eeop));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Random-phase model state
  int        ptr_m, lock_u, g, len;
  bit        locked_m, ev, w;
  int unsigned perf_m;
  commit_t   ec, b;
  commit_t   uq [N][$];
  logic [N-1:0] v, er;
  int        remaining;

  initial begin
    // Reset state, with every unit requesting to prove ready is gated.
    for (int u = 0; u < N; u++) drv(u, 1'b1, mk(u, 1'b1, 1'b1, 1'b1, 6'd1));
    #12;
    chk("reset.ready", 64'(bus.commit_ready), 64'd0);
    chk("reset.wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("reset.wb_data_zero", 64'(bus.wb_data == '0), 64'd1);
    chk("reset.perf", 64'(perf_commits), 64'd0);
    idle_all();
    @(negedge clk);
    reset = 1'b1;

    //          vld      wb   rdb    rdy      wbv  rd     wis   perf
    tbl[0]  = '{4'b1000, 1'b1, 6'd2,  4'b1000, 1'b0, 6'd0,  2'd0, 32'd0};
    tbl[1]  = '{4'b1000, 1'b1, 6'd3,  4'b1000, 1'b1, 6'd5,  2'd3, 32'd0};
    tbl[2]  = '{4'b1000, 1'b1, 6'd4,  4'b1000, 1'b1, 6'd6,  2'd3, 32'd1};
    tbl[3]  = '{4'b0000, 1'b1, 6'd0,  4'b0000, 1'b1, 6'd7,  2'd3, 32'd2};
    tbl[4]  = '{4'b1111, 1'b1, 6'd16, 4'b0001, 1'b0, 6'd0,  2'd0, 32'd3};
    tbl[5]  = '{4'b1111, 1'b1, 6'd16, 4'b0010, 1'b1, 6'd16, 2'd0, 32'd3};
    tbl[6]  = '{4'b1111, 1'b1, 6'd16, 4'b0100, 1'b1, 6'd17, 2'd1, 32'd4};
    tbl[7]  = '{4'b1111, 1'b1, 6'd16, 4'b1000, 1'b1, 6'd18, 2'd2, 32'd5};
    tbl[8]  = '{4'b1111, 1'b1, 6'd16, 4'b0001, 1'b1, 6'd19, 2'd3, 32'd6};
    tbl[9]  = '{4'b0000, 1'b1, 6'd0,  4'b0000, 1'b1, 6'd16, 2'd0, 32'd7};
    tbl[10] = '{4'b0001, 1'b0, 6'd20, 4'b0001, 1'b0, 6'd0,  2'd0, 32'd8};
    tbl[11] = '{4'b0001, 1'b1, 6'd9,  4'b0001, 1'b0, 6'd0,  2'd0, 32'd8};
    tbl[12] = '{4'b0000, 1'b1, 6'd0,  4'b0000, 1'b1, 6'd9,  2'd0, 32'd8};
    tbl[13] = '{4'b0000, 1'b1, 6'd0,  4'b0000, 1'b0, 6'd0,  2'd0, 32'd9};

    for (int i = 0; i < 14; i++) begin
      next_cycle();
      for (int u = 0; u < N; u++)
        drv(u, tbl[i].vld[u], mk(u, 1'b1, 1'b1, tbl[i].wb, 6'(tbl[i].rdb + 6'(u))));
      @(negedge clk);
      chk_wb($sformatf("vec%0d", i), tbl[i].exp_rdy, tbl[i].exp_wbv,
             tbl[i].exp_rd, tbl[i].exp_wis, 1'b1);
      if (tbl[i].exp_wbv)
        chk($sformatf("vec%0d.pc", i), 64'(bus.wb_data.PC), 64'(32'h100 + 32'(tbl[i].exp_rd)));
      chk($sformatf("vec%0d.perf", i), 64'(perf_commits), 64'(tbl[i].exp_perf));
    end

    // Locked 3-beat packet on unit 1 with a gap before eop; unit 2 waits.
    next_cycle(); drv(1, 1'b1, mk(1, 1'b1, 1'b0, 1'b1, 6'd30)); drv(2, 1'b1, mk(2, 1'b1, 1'b1, 1'b1, 6'd40));
    @(negedge clk); chk_wb("lock.c0", 4'b0010, 1'b0, 6'd0, 2'd0, 1'b0);
    next_cycle(); drv(1, 1'b1, mk(1, 1'b0, 1'b0, 1'b1, 6'd31));
    @(negedge clk); chk_wb("lock.c1", 4'b0010, 1'b1, 6'd30, 2'd1, 1'b0);
    chk("lock.c1.sop", 64'(bus.wb_data.sop), 64'd1);
    next_cycle(); drv(1, 1'b0, '0);
    @(negedge clk); chk_wb("lock.gap", 4'b0000, 1'b1, 6'd31, 2'd1, 1'b0);
    next_cycle(); drv(1, 1'b1, mk(1, 1'b0, 1'b1, 1'b1, 6'd32));
    @(negedge clk); chk_wb("lock.c3", 4'b0010, 1'b0, 6'd0, 2'd0, 1'b0);
    next_cycle(); drv(1, 1'b0, '0);
    @(negedge clk); chk_wb("lock.c4", 4'b0100, 1'b1, 6'd32, 2'd1, 1'b1);
    next_cycle(); idle_all();
    @(negedge clk); chk_wb("lock.c5", 4'b0000, 1'b1, 6'd40, 2'd2, 1'b1);

    // Reset in the middle of a unit-3 packet.
    next_cycle(); drv(3, 1'b1, mk(3, 1'b1, 1'b0, 1'b1, 6'd50));
    @(negedge clk); chk_wb("rst.c6", 4'b1000, 1'b0, 6'd0, 2'd0, 1'b0);
    next_cycle(); drv(3, 1'b1, mk(3, 1'b0, 1'b0, 1'b1, 6'd51)); drv(0, 1'b1, mk(0, 1'b1, 1'b1, 1'b1, 6'd52));
    #1;
    chk_wb("rst.pre", 4'b1000, 1'b1, 6'd50, 2'd3, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst.async_ready", 64'(bus.commit_ready), 64'd0);
    chk("rst.async_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst.async_wb_data", 64'(bus.wb_data == '0), 64'd1);
    drv(3, 1'b1, mk(3, 1'b1, 1'b1, 1'b1, 6'd53));
    @(posedge clk); #1;
    chk("rst.perf", 64'(perf_commits), 64'd0);
    @(negedge clk); reset = 1'b1; #1;
    chk("rst.ptr0_ready", 64'(bus.commit_ready), 64'b0001);
    next_cycle(); drv(0, 1'b0, '0);
    @(negedge clk); chk_wb("rst.after1", 4'b1000, 1'b1, 6'd52, 2'd0, 1'b1);
    next_cycle(); idle_all();
    @(negedge clk); chk_wb("rst.after2", 4'b0000, 1'b1, 6'd53, 2'd3, 1'b1);

    // perf_commits wrap.
    next_cycle(); next_cycle();
    force dut.perf_q = 32'hFFFF_FFFF;
    next_cycle();
    release dut.perf_q;
    @(negedge clk); chk("wrap.preload", 64'(perf_commits), 64'hFFFF_FFFF);
    next_cycle(); drv(0, 1'b1, mk(0, 1'b1, 1'b1, 1'b1, 6'd60));
    @(negedge clk); chk("wrap.ready", 64'(bus.commit_ready), 64'b0001);
    next_cycle(); idle_all();
    next_cycle();
    @(negedge clk); chk("wrap.perf", 64'(perf_commits), 64'd0);

    // Randomized run against the reference model, from a fresh reset.
    next_cycle(); reset = 1'b0;
    next_cycle();
    @(negedge clk); reset = 1'b1;
    ptr_m = 0; locked_m = 1'b0; lock_u = 0; perf_m = 0; ev = 1'b0; ec = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      next_cycle();
      for (int u = 0; u < N; u++) begin
        if (cyc < 600 && uq[u].size() == 0 && $urandom_range(0, 2) == 0) begin
          len = $urandom_range(1, 3);
          w   = ($urandom_range(0, 3) != 0);
          for (int k = 0; k < len; k++)
            uq[u].push_back(mk(u, k == 0, k == len - 1, w, 6'($urandom)));
        end
        v[u] = (uq[u].size() != 0) && ($urandom_range(0, 3) != 0);
        drv(u, v[u], (uq[u].size() != 0) ? uq[u][0] : commit_t'('0));
      end
      g = -1;
      if (locked_m) begin
        if (v[lock_u]) g = lock_u;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
      er = (g >= 0) ? N'(1 << g) : '0;
      @(negedge clk);
      chk_wb("rand", er, ev, ec.rd, ec.wis, ec.eop);
      if (ev) chk("rand.data1", 64'(bus.wb_data.data[1]), 64'(ec.data[1]));
      chk("rand.perf", 64'(perf_commits), 64'(perf_m));
      if (ev && ec.eop) perf_m++;
      ev = 1'b0;
      if (g >= 0) begin
        b  = uq[g].pop_front();
        ev = b.wb;
        ec = b;
        if (b.eop) begin
          locked_m = 1'b0;
          ptr_m    = (g + 1) % N;
        end else begin
          locked_m = 1'b1;
          lock_u   = g;
        end
      end
    end
    remaining = 0;
    for (int u = 0; u < N; u++) remaining += uq[u].size();
    chk("rand.drained", 64'(remaining), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
